tx_serializer: RTL and testbench
================================

TX_SERIALIZER -- requirements
Module: tx_serializer

Interface
REQ-001 Parameter DATA_BITS, default 8, SHALL set the number of data bits per frame (legal range 5..8).
REQ-002 Parameter CLKS_PER_BIT, default 16, SHALL set the number of clk cycles per serial bit (legal minimum 2).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 Port tx_cek  input  1  SHALL be the one-cycle load strobe from the upstream tx_en edge detector.
REQ-006 Port tx_data  input  DATA_BITS  SHALL carry the byte to send, sampled only on an accepted load.
REQ-007 Port tx_out  output  1  SHALL be the serial line, idle high.
REQ-008 Port tx_busy  output  1  SHALL be high while a frame is in progress.
REQ-009 Port tx_done  output  1  SHALL pulse high for one cycle when a frame's stop bit completes.

Function
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-011 IDLE: tx_out=1, tx_busy=0; on tx_cek=1, latch tx_data into the shift register, clear the bit-cycle counter, and go to START.
REQ-012 Latency: tx_cek sampled high at edge N SHALL drive tx_out=0 and tx_busy=1 from edge N (visible in cycle N+1); all outputs registered.
REQ-013 START SHALL hold tx_out=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-014 DATA SHALL send the latched bits LSB first, each for exactly CLKS_PER_BIT cycles; after bit DATA_BITS-1 go to STOP.
REQ-015 STOP SHALL hold tx_out=1 for exactly CLKS_PER_BIT cycles, then go to IDLE, set tx_busy=0, and assert tx_done for one cycle.
REQ-016 One frame SHALL last exactly (DATA_BITS+2)*CLKS_PER_BIT cycles from the first low cycle of tx_out to tx_busy falling.
REQ-017 tx_cek while tx_busy=1 SHALL be ignored; the frame in flight and the latched data SHALL NOT change.
REQ-018 tx_cek in the cycle tx_done=1 (state IDLE) SHALL be accepted, giving back-to-back frames with exactly one idle-high cycle between stop and the next start.
REQ-019 tx_data changes after acceptance SHALL NOT affect the frame in flight.
REQ-020 Bit-cycle counter width SHALL be $clog2(CLKS_PER_BIT); bit index width SHALL be $clog2(DATA_BITS); counters SHALL wrap only under FSM control, never free-run.
REQ-021 Unreachable state encodings SHALL return to IDLE on the next edge with tx_out=1.

Reset
REQ-022 reset=1 at an edge SHALL force state=IDLE, tx_out=1, tx_busy=0, tx_done=0, and clear counters and shift register, even mid-frame.
REQ-023 reset SHALL take priority over tx_cek in the same cycle; the load is dropped.
REQ-024 After reset release, the first tx_cek SHALL be accepted normally.

Structure
REQ-025 Package tx_pkg SHALL hold the FSM state typedef (2-bit: IDLE=00, START=01, DATA=10, STOP=11) and the default DATA_BITS/CLKS_PER_BIT constants.
REQ-026 The bit-period counter SHALL be a sub-module bit_timer (inputs clk, reset, clear; output bit_end when the count reaches CLKS_PER_BIT-1).

Verification (DATA_BITS=8, CLKS_PER_BIT=4)
REQ-027 Reset, then idle for 20 cycles -> tx_out=1, tx_busy=0, tx_done=0 throughout.
REQ-028 tx_cek pulse with tx_data=0xA5 -> tx_out in 4-cycle bits: 0, 1,0,1,0,0,1,0,1, 1; tx_busy high for 40 cycles; one tx_done pulse.
REQ-029 Load 0x3C, then pulse tx_cek with tx_data=0xFF at cycles 10 and 25 -> only 0x3C is sent; no extra frame.
REQ-030 Load 0x01, then pulse tx_cek with 0x80 in the tx_done cycle -> one idle cycle, then frame 0x80; total 81 cycles from the first start bit to the final tx_busy fall.
REQ-031 reset asserted at cycle 17 of a 0x55 frame -> tx_out=1 and tx_busy=0 from the next edge; no tx_done; a following load of 0xC3 serializes correctly.
REQ-032 reset and tx_cek high in the same cycle -> no frame; tx_out stays 1.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared FSM encoding and default frame parameters for the serial transmitter.
package tx_pkg;

    localparam int DEF_DATA_BITS    = 8;
    localparam int DEF_CLKS_PER_BIT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } tx_state_t;

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: bit_end marks the last clk of each serial bit; held at zero while clear is high.
// Latency: bit_end is combinational from the count; no backpressure.
module bit_timer
    import tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_end = (cnt == CNT_LAST);

endmodule

// File: rtl/tx_serializer.sv
// UART-style serializer: start bit, DATA_BITS LSB first, one stop bit; all outputs registered.
// Latency: accepted tx_cek drives the start bit from the same edge; tx_cek is dropped while busy.
module tx_serializer
    import tx_pkg::*;
#(
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_cek,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int               IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    tx_state_t            state_q, state_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [IDX_W-1:0]     bit_idx, idx_nxt;
    logic                 tx_out_nxt, busy_nxt, done_nxt;
    logic                 timer_clear;
    logic                 bit_end;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            tx_out  <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state_q <= state_nxt;
            shreg   <= shreg_nxt;
            bit_idx <= idx_nxt;
            tx_out  <= tx_out_nxt;
            tx_busy <= busy_nxt;
            tx_done <= done_nxt;
        end
    end

    // Outputs are computed one state ahead so the registered line changes on the transition edge.
    always_comb begin
        state_nxt   = state_q;
        shreg_nxt   = shreg;
        idx_nxt     = bit_idx;
        tx_out_nxt  = tx_out;
        busy_nxt    = tx_busy;
        done_nxt    = 1'b0;
        timer_clear = 1'b0;

        case (state_q)
            IDLE: begin
                timer_clear = 1'b1;
                tx_out_nxt  = 1'b1;
                busy_nxt    = 1'b0;
                if (tx_cek) begin
                    shreg_nxt  = tx_data;
                    idx_nxt    = '0;
                    state_nxt  = START;
                    tx_out_nxt = 1'b0;
                    busy_nxt   = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt  = DATA;
                    idx_nxt    = '0;
                    tx_out_nxt = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == IDX_LAST) begin
                        state_nxt  = STOP;
                        tx_out_nxt = 1'b1;
                    end else begin
                        idx_nxt    = bit_idx + 1'b1;
                        shreg_nxt  = shreg >> 1;
                        tx_out_nxt = shreg[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nxt  = IDLE;
                    tx_out_nxt = 1'b1;
                    busy_nxt   = 1'b0;
                    done_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                tx_out_nxt  = 1'b1;
                busy_nxt    = 1'b0;
                timer_clear = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_tx_serializer.sv
// Directed bench for tx_serializer with DATA_BITS=8, CLKS_PER_BIT=4.
module tb_tx_serializer;

    localparam int DB  = 8;
    localparam int CPB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          tx_cek;
    logic [DB-1:0] tx_data;
    logic          tx_out;
    logic          tx_busy;
    logic          tx_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    tx_serializer #(
        .DATA_BITS    (DB),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_cek  (tx_cek),
        .tx_data (tx_data),
        .tx_out  (tx_out),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    // Line pattern index 0 = start bit, 1..8 = data LSB first, 9 = stop bit.
    typedef struct {
        logic [DB-1:0] data;
        logic [9:0]    line;
        bit            noise;
    } frame_vec_t;

    frame_vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_out"},  {31'd0, tx_out},  32'd1);
        check({name, "_busy"}, {31'd0, tx_busy}, 32'd0);
        check({name, "_done"}, {31'd0, tx_done}, 32'd0);
    endtask

    // Pulse tx_cek for one cycle, then scramble tx_data so later changes are visible if latched.
    task automatic load(input logic [DB-1:0] d);
        tx_cek  = 1'b1;
        tx_data = d;
        tick();
        tx_cek  = 1'b0;
        tx_data = ~d;
    endtask

    // Checks ncyc cycles of a frame body; noise issues ignored loads with 0xFF at cycles 10 and 25.
    task automatic body(input logic [9:0] line, input bit noise, input int ncyc);
        logic [9:0] l;
        l = line;
        for (int k = 0; k < ncyc; k++) begin
            check("frame_out",  {31'd0, tx_out},  {31'd0, l[k / CPB]});
            check("frame_busy", {31'd0, tx_busy}, 32'd1);
            check("frame_done", {31'd0, tx_done}, 32'd0);
            if (noise && (k == 10 || k == 25)) begin
                tx_cek  = 1'b1;
                tx_data = 8'hFF;
            end else begin
                tx_cek  = 1'b0;
            end
            tick();
        end
        tx_cek = 1'b0;
    endtask

    task automatic frame_end_done();
        check("end_out",  {31'd0, tx_out},  32'd1);
        check("end_busy", {31'd0, tx_busy}, 32'd0);
        check("end_done", {31'd0, tx_done}, 32'd1);
    endtask

    initial begin
        int t0;

        vecs[0] = '{data: 8'hA5, line: 10'b1_1010_0101_0, noise: 1'b0};
        vecs[1] = '{data: 8'h3C, line: 10'b1_0011_1100_0, noise: 1'b1};
        vecs[2] = '{data: 8'h00, line: 10'b1_0000_0000_0, noise: 1'b0};
        vecs[3] = '{data: 8'hFF, line: 10'b1_1111_1111_0, noise: 1'b1};
        vecs[4] = '{data: 8'h6B, line: 10'b1_0110_1011_0, noise: 1'b0};

        reset   = 1'b1;
        tx_cek  = 1'b0;
        tx_data = '0;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            check_idle("idle20");
        end

        // Table-driven frames, each followed by a quiet cycle after tx_done.
        for (int i = 0; i < 5; i++) begin
            load(vecs[i].data);
            body(vecs[i].line, vecs[i].noise, 40);
            frame_end_done();
            tick();
            check_idle("post_frame");
            for (int k = 0; k < 12; k++) begin
                tick();
                check("no_extra_busy", {31'd0, tx_busy}, 32'd0);
            end
        end

        // Back-to-back: reload in the tx_done cycle.
        load(8'h01);
        t0 = cyc;
        body(10'b1_0000_0001_0, 1'b0, 40);
        frame_end_done();
        load(8'h80);
        check("gap_cycles", cyc - t0, 32'd41);
        body(10'b1_1000_0000_0, 1'b0, 40);
        frame_end_done();
        check("b2b_total", cyc - t0, 32'd81);
        tick();
        check_idle("after_b2b");

        // Reset in the middle of a 0x55 frame.
        load(8'h55);
        body(10'b1_0101_0101_0, 1'b0, 17);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("mid_reset");
        for (int k = 0; k < 45; k++) begin
            tick();
            check("no_done_after_reset", {31'd0, tx_done}, 32'd0);
        end

        load(8'hC3);
        body(10'b1_1100_0011_0, 1'b0, 40);
        frame_end_done();
        tick();
        check_idle("after_c3");

        // Reset and load in the same cycle: load dropped.
        reset   = 1'b1;
        tx_cek  = 1'b1;
        tx_data = 8'h0F;
        tick();
        reset   = 1'b0;
        tx_cek  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check_idle("reset_vs_cek");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
